reg_write_ctrl: RTL and testbench
=================================

# reg_write_ctrl

Write-side controller for the integer register file: the single point that drives the file's write port (WE3/AD3/WD3). It merges the in-order pipeline writeback with results from a multi-cycle execution unit (mul/div), buffers a colliding multi-cycle result in a one-entry hold register, and keeps a 32-entry busy scoreboard. Decode queries the scoreboard to stall reads of registers with an outstanding multi-cycle write. It sits between the writeback stage / multi-cycle unit and the register file.

## Interface
- ADDRESS_WIDTH, 5, register address width (32 architectural registers)
- DATA_WIDTH, 32, register data width

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- wb_we  in  1  pipeline writeback valid; highest priority, never back-pressured
- wb_rd  in  ADDRESS_WIDTH  pipeline destination register
- wb_data  in  DATA_WIDTH  pipeline result
- issue_valid  in  1  multi-cycle op issued this cycle (claims issue_rd)
- issue_rd  in  ADDRESS_WIDTH  destination of issued multi-cycle op
- issue_ok  out  1  combinational; !busy[issue_rd] (issuing when 0 is illegal)
- mc_valid  in  1  multi-cycle result valid
- mc_rd  in  ADDRESS_WIDTH  multi-cycle result destination
- mc_data  in  DATA_WIDTH  multi-cycle result data
- mc_ready  out  1  result accepted when mc_valid & mc_ready
- rs1, rs2  in  ADDRESS_WIDTH  decode source addresses
- stall  out  1  combinational; busy[rs1] | busy[rs2] | (issue_valid & !issue_ok)
- WE3  out  1  register-file write enable
- AD3  out  ADDRESS_WIDTH  register-file write address
- WD3  out  DATA_WIDTH  register-file write data

## Operation
- State: busy[31:0], hold_valid, hold_rd, hold_data.
- Port select per cycle, priority order: (1) wb_we → port = wb_rd/wb_data; (2) hold_valid → port = hold; (3) mc_valid & mc_ready → port = mc_rd/mc_data direct; (4) idle: WE3 = 0.
- WE3 forced 0 whenever the selected AD3 is 0 (x0 never written); AD3/WD3 still reflect the selection.
- mc_ready = !hold_valid & !rst.
- Accepted mc result with wb_we = 1 → captured into hold (hold_valid ← 1). Accepted with wb_we = 0 and hold empty → written directly, not held.
- Hold drains in the first cycle with wb_we = 0; hold_valid ← 0 that posedge.
- Scoreboard set: issue_valid & issue_rd != 0 → busy[issue_rd] ← 1.
- Scoreboard clear: busy[r] ← 0 in the cycle the multi-cycle value for r drives the port (direct or from hold). Capture into hold does not clear.
- Same register set and cleared same cycle: set wins.
- busy[0] is constant 0.
- wb_we to a busy register is a WAW hazard prevented upstream by stall; if it occurs, the write proceeds and busy is unchanged.

## Timing
- Reset (rst high at posedge): busy = 0, hold_valid = 0. While rst is high: mc_ready = 0, WE3 = 0, AD3 = 0, WD3 = 0, stall = 0, issue_ok = 1.
- Write port is combinational from inputs/state; the register file samples it on the following negedge (same-cycle write).
- Direct mc write: 0 added latency. Held mc write: 1+ cycles, drains in the first cycle with wb_we = 0.
- busy bit visible to stall/issue_ok the cycle after the issue posedge; cleared the cycle after the drain/write posedge.
- Max one mc result in flight in the block; mc_ready low exactly while hold_valid.
- Reset mid-operation discards the hold contents and all busy bits; the dropped write never reaches the port.

## Test plan
- Reset: assert rst 2 cycles with mc_valid=1, wb_we=1 → WE3=0, mc_ready=0, busy=0, stall=0 throughout.
- Direct mc: issue x5, then mc_valid with x5=0xDEADBEEF, wb_we=0 → same-cycle WE3=1, AD3=5, WD3=0xDEADBEEF; stall with rs1=5 is 1 until the cycle after, then 0.
- Collision: wb_we x3=0x11 with mc x7=0x22 → cycle n port x3/0x11, hold captures; mc_ready=0 at n+1; wb_we=0 at n+1 → port x7/0x22, busy[7] clears.
- Hold under sustained wb: wb_we for 4 cycles after capture → hold retained, mc_ready=0; drains on cycle 5.
- x0: wb_we to x0 with 0xFF → WE3=0; issue to x0 → no busy bit set, issue_ok=1.
- Set/clear same reg: mc x9 write and issue x9 same cycle → write occurs, busy[9]=1 afterward; rst mid-hold → no write, hold_valid=0.

Source files
------------

// File: rtl/reg_write_ctrl.sv
// Register-file write-port controller: merges pipeline writeback with multi-cycle
// results, buffers one colliding result, and tracks outstanding multi-cycle writes.
module reg_write_ctrl #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [ADDRESS_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    input  logic                     issue_valid,
    input  logic [ADDRESS_WIDTH-1:0] issue_rd,
    output logic                     issue_ok,
    input  logic                     mc_valid,
    input  logic [ADDRESS_WIDTH-1:0] mc_rd,
    input  logic [DATA_WIDTH-1:0]    mc_data,
    output logic                     mc_ready,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    output logic                     stall,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]    WD3
);

    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_HOLD,
        SRC_MC
    } src_e;

    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic                     hold_valid_q, hold_valid_d;
    logic [ADDRESS_WIDTH-1:0] hold_rd_q, hold_rd_d;
    logic [DATA_WIDTH-1:0]    hold_data_q, hold_data_d;

    src_e src;
    logic mc_accept;

    assign mc_ready  = !hold_valid_q && !rst;
    assign mc_accept = mc_valid && mc_ready;

    // Write-port source, highest priority first; reset masks every source.
    always_comb begin
        src = SRC_NONE;
        if (!rst) begin
            if (wb_we)
                src = SRC_WB;
            else if (hold_valid_q)
                src = SRC_HOLD;
            else if (mc_accept)
                src = SRC_MC;
        end
    end

    always_comb begin
        AD3 = '0;
        WD3 = '0;
        case (src)
            SRC_WB: begin
                AD3 = wb_rd;
                WD3 = wb_data;
            end
            SRC_HOLD: begin
                AD3 = hold_rd_q;
                WD3 = hold_data_q;
            end
            SRC_MC: begin
                AD3 = mc_rd;
                WD3 = mc_data;
            end
            default: begin
                AD3 = '0;
                WD3 = '0;
            end
        endcase
        WE3 = (src != SRC_NONE) && (AD3 != '0);
    end

    assign issue_ok = rst ? 1'b1 : !busy_q[issue_rd];
    assign stall    = rst ? 1'b0
                    : (busy_q[rs1] || busy_q[rs2] || (issue_valid && !issue_ok));

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        if (wb_we && mc_accept) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = mc_rd;
            hold_data_d  = mc_data;
        end else if (src == SRC_HOLD) begin
            hold_valid_d = 1'b0;
        end
    end

    // Clears come from the value reaching the port; a same-cycle issue re-sets the bit.
    always_comb begin
        busy_d = busy_q;
        if (src == SRC_HOLD)
            busy_d[hold_rd_q] = 1'b0;
        if (src == SRC_MC)
            busy_d[mc_rd] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
        end
    end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Bench for reg_write_ctrl: directed scenarios plus random traffic, all outputs
// compared each cycle against a queue/array reference model.
module tb_reg_write_ctrl;

    logic        clk = 1'b0;
    logic        rst, wb_we, issue_valid, mc_valid;
    logic [4:0]  wb_rd, issue_rd, mc_rd, rs1, rs2;
    logic [31:0] wb_data, mc_data;
    logic        issue_ok, mc_ready, stall, WE3;
    logic [4:0]  AD3;
    logic [31:0] WD3;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    bit  sb[32];
    wr_t hold_q[$];

    always #5 clk = ~clk;

    reg_write_ctrl #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ok(issue_ok),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .rs1(rs1), .rs2(rs2), .stall(stall),
        .WE3(WE3), .AD3(AD3), .WD3(WD3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs after the falling edge and compare against the model.
    task automatic drive(input logic r, input logic we, input logic [4:0] wrd,
                         input logic [31:0] wdat, input logic iv, input logic [4:0] ird,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                         input logic [4:0] s1, input logic [4:0] s2);
        bit   sel;
        wr_t  p;
        logic e_ok, e_stall, e_rdy;
        @(negedge clk);
        rst = r; wb_we = we; wb_rd = wrd; wb_data = wdat;
        issue_valid = iv; issue_rd = ird;
        mc_valid = mv; mc_rd = mrd; mc_data = mdat;
        rs1 = s1; rs2 = s2;
        #1;
        sel = 0;
        p = '{5'd0, 32'd0};
        if (r) begin
            e_rdy = 0; e_ok = 1; e_stall = 0;
        end else begin
            e_rdy = (hold_q.size() == 0);
            if (we) begin
                sel = 1; p = '{wrd, wdat};
            end else if (hold_q.size() > 0) begin
                sel = 1; p = hold_q[0];
            end else if (mv) begin
                sel = 1; p = '{mrd, mdat};
            end
            e_ok    = !sb[ird];
            e_stall = sb[s1] | sb[s2] | (iv & !e_ok);
        end
        check_eq("we3", WE3, sel && (p.rd != 0));
        if (sel || r) begin
            check_eq("ad3", AD3, p.rd);
            check_eq("wd3", WD3, p.data);
        end
        check_eq("mc_ready", mc_ready, e_rdy);
        check_eq("issue_ok", issue_ok, e_ok);
        check_eq("stall", stall, e_stall);
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        if (rst) begin
            foreach (sb[i]) sb[i] = 0;
            hold_q.delete();
        end else begin
            acc = mc_valid && (hold_q.size() == 0);
            if (wb_we) begin
                if (acc) hold_q.push_back('{mc_rd, mc_data});
            end else if (hold_q.size() > 0) begin
                sb[hold_q[0].rd] = 0;
                void'(hold_q.pop_front());
            end else if (acc) begin
                sb[mc_rd] = 0;
            end
            if (issue_valid && issue_rd != 0) sb[issue_rd] = 1;
        end
    endtask

    task automatic idle(input logic [4:0] s1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, s1, 0);
    endtask

    initial begin
        rst = 1; wb_we = 0; wb_rd = 0; wb_data = 0; issue_valid = 0; issue_rd = 0;
        mc_valid = 0; mc_rd = 0; mc_data = 0; rs1 = 0; rs2 = 0;

        // Reset with traffic present
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 5'd4, 32'h1234, 1, 5'd4, 1, 5'd6, 32'h55, 5'd4, 5'd6);
            check_eq("rst_we3", WE3, 0);
            check_eq("rst_mc_ready", mc_ready, 0);
            check_eq("rst_stall", stall, 0);
            tick();
        end

        // Direct multi-cycle write
        drive(0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 5'd5, 0);
        check_eq("issue_stall_same_cycle", stall, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 0);
        check_eq("direct_stall", stall, 1);
        check_eq("direct_we3", WE3, 1);
        check_eq("direct_ad3", AD3, 5);
        check_eq("direct_wd3", WD3, 32'hDEADBEEF);
        tick();
        idle(5'd5);
        check_eq("direct_stall_after", stall, 0);
        tick();

        // Collision with writeback
        drive(0, 0, 0, 0, 1, 5'd7, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 5'd3, 32'h11, 0, 0, 1, 5'd7, 32'h22, 5'd7, 0);
        check_eq("coll_ad3", AD3, 3);
        check_eq("coll_wd3", WD3, 32'h11);
        tick();
        idle(5'd7);
        check_eq("coll_mc_ready", mc_ready, 0);
        check_eq("coll_drain_ad3", AD3, 7);
        check_eq("coll_drain_wd3", WD3, 32'h22);
        check_eq("coll_stall_during_drain", stall, 1);
        tick();
        idle(5'd7);
        check_eq("coll_busy_cleared", stall, 0);
        tick();

        // Hold under sustained writeback
        drive(0, 0, 0, 0, 1, 5'd8, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 5'd4, 32'h44, 0, 0, 1, 5'd8, 32'h88, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 5'(10 + i), 32'(i), 0, 0, 1, 5'd9, 32'h99, 5'd8, 0);
            check_eq("sustain_mc_ready", mc_ready, 0);
            check_eq("sustain_ad3", AD3, 5'(10 + i));
            tick();
        end
        idle(5'd8);
        check_eq("sustain_drain_ad3", AD3, 8);
        check_eq("sustain_drain_wd3", WD3, 32'h88);
        tick();

        // Register x0
        drive(0, 1, 5'd0, 32'hFF, 1, 5'd0, 0, 0, 0, 0, 0);
        check_eq("x0_we3", WE3, 0);
        check_eq("x0_issue_ok", issue_ok, 1);
        tick();
        drive(0, 0, 0, 0, 1, 5'd0, 0, 0, 0, 5'd0, 5'd0);
        check_eq("x0_not_busy", stall, 0);
        tick();

        // Set and clear of the same register in one cycle
        drive(0, 0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 5'd9, 1, 5'd9, 32'h9999, 0, 0);
        check_eq("setclr_we3", WE3, 1);
        check_eq("setclr_ad3", AD3, 9);
        tick();
        idle(5'd9);
        check_eq("setclr_busy_kept", stall, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h1, 0, 0);
        tick();

        // Reset while a result sits in hold
        drive(0, 0, 0, 0, 1, 5'd6, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 5'd2, 32'h2, 0, 0, 1, 5'd6, 32'h66, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rsthold_we3", WE3, 0);
        tick();
        idle(5'd6);
        check_eq("rsthold_we3_after", WE3, 0);
        check_eq("rsthold_mc_ready", mc_ready, 1);
        check_eq("rsthold_stall", stall, 0);
        tick();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
